// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle MULT/DIV sequencer owning HI/LO; MULDIV_MTHILO_EN enables MTHI/MTLO
module muldiv_sequencer #(
    parameter int MULT_LAT  = 4,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_hi,
    input  logic        rd_lo,
    input  logic        wr_hi,
    input  logic        wr_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        div0
);
    localparam int CNT_W = (MULT_LAT > DIV_ITERS) ? $clog2(MULT_LAT) : $clog2(DIV_ITERS);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        prod;
    logic [31:0]        divisor;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic               sign_q;
    logic               sign_r;

    logic               mt_hi;
    logic               mt_lo;
    logic [63:0]        prod_full;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [32:0]        rem_sh;
    logic               trial_ok;
    logic [31:0]        rem_next;

`ifdef MULDIV_MTHILO_EN
    assign mt_hi = wr_hi;
    assign mt_lo = wr_lo;
`else
    logic unused_mt;
    assign unused_mt = wr_hi ^ wr_lo;
    assign mt_hi = 1'b0;
    assign mt_lo = 1'b0;
`endif

    assign prod_full = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign abs_a     = src_a[31] ? -src_a : src_a;
    assign abs_b     = src_b[31] ? -src_b : src_b;

    // Restoring step: quo doubles as the dividend shift register, MSB first.
    assign rem_sh    = {rem, quo[31]};
    assign trial_ok  = (rem_sh >= {1'b0, divisor});
    assign rem_next  = trial_ok ? (rem_sh[31:0] - divisor) : rem_sh[31:0];

    assign busy  = (state != IDLE);
    assign stall = busy & (start_mult | start_div | rd_hi | rd_lo | mt_hi | mt_lo);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            prod    <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            div0    <= 1'b0;
        end else begin
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        prod  <= prod_full;
                        cnt   <= CNT_W'(MULT_LAT - 1);
                        state <= MULT;
                    end else if (start_div) begin
                        if (src_b == 32'd0) begin
                            hi   <= src_a;
                            lo   <= 32'hFFFF_FFFF;
                            div0 <= 1'b1;
                        end else begin
                            quo     <= abs_a;
                            divisor <= abs_b;
                            rem     <= '0;
                            sign_q  <= src_a[31] ^ src_b[31];
                            sign_r  <= src_a[31];
                            cnt     <= CNT_W'(DIV_ITERS - 1);
                            state   <= DIV;
                        end
                    end else begin
                        if (mt_hi) hi <= src_a;
                        if (mt_lo) lo <= src_a;
                    end
                end
                MULT: begin
                    if (cnt == '0) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV: begin
                    quo <= {quo[30:0], trial_ok};
                    rem <= rem_next;
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                FIX: begin
                    lo    <= sign_q ? -quo : quo;
                    hi    <= sign_r ? -rem : rem;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer against an arithmetic reference model
module tb_muldiv_sequencer;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        rd_hi = 1'b0;
    logic        rd_lo = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        div0;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_sequencer #(.MULT_LAT(MULT_LAT), .DIV_ITERS(32)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .src_a(src_a), .src_b(src_b), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .hi(hi), .lo(lo), .busy(busy),
        .stall(stall), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic; SV / and % truncate toward zero.
    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        int     sa, sb;
        longint la, lb, p, q, r;
        sa = a; sb = b; la = sa; lb = sb;
        if (!is_div) begin
            p = la * lb; eh = p[63:32]; el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a; el = 32'hFFFF_FFFF;
        end else begin
            q = la / lb; r = la % lb; eh = r[31:0]; el = q[31:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // mode 0: plain, 1: rd_lo held while busy, 2: start_mult pulse mid-op
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [31:0] eh, el, old_hi, old_lo;
        int n;
        model(is_div, a, b, eh, el);
        old_hi = hi; old_lo = lo; n = 0;
        src_a = a; src_b = b;
        if (is_div) start_div = 1'b1; else start_mult = 1'b1;
        #1;
        check("idle_no_stall", {31'd0, stall}, 32'd0);
        tick();
        start_div = 1'b0; start_mult = 1'b0;
        if (is_div && b == 32'd0) begin
            check("div0_busy", {31'd0, busy}, 32'd0);
            check("div0_pulse", {31'd0, div0}, 32'd1);
            check("div0_hi", hi, eh);
            check("div0_lo", lo, el);
            tick();
            check("div0_clear", {31'd0, div0}, 32'd0);
            return;
        end
        if (mode == 1) rd_lo = 1'b1;
        while (busy && n < 100) begin
            if (mode == 2) start_mult = (n == 5);
            #1;
            check("stall_busy", {31'd0, stall}, {31'd0, (mode == 1) || (mode == 2 && n == 5)});
            check("hi_held", hi, old_hi);
            check("lo_held", lo, old_lo);
            n++;
            tick();
        end
        start_mult = 1'b0;
        check("latency", n, is_div ? DIV_LAT : MULT_LAT);
        check("done_stall", {31'd0, stall}, 32'd0);
        check("res_hi", hi, eh);
        check("res_lo", lo, el);
        rd_lo = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rdiv;
        tick(); tick();
        reset = 1'b0;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_div0", {31'd0, div0}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);

        // Seed HI/LO, then reset in the middle of a divide.
        run_op(0, 32'd11, 32'd13, 0);
        src_a = 32'd1000; src_b = 32'd7; start_div = 1'b1;
        tick();
        start_div = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (40) tick();
        check("abort_nowrite_hi", hi, 32'd0);
        check("abort_nowrite_lo", lo, 32'd0);

        run_op(0, 32'd7, -32'sd3, 0);
        check("mult_7x-3_hi", hi, 32'hFFFF_FFFF);
        check("mult_7x-3_lo", lo, 32'hFFFF_FFEB);
        run_op(1, -32'sd7, 32'd2, 0);
        check("div_-7/2_lo", lo, 32'hFFFF_FFFD);
        check("div_-7/2_hi", hi, 32'hFFFF_FFFF);
        run_op(1, 32'd5, 32'd0, 0);
        run_op(1, 32'd100, 32'd9, 1);
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("intmin_lo", lo, 32'h8000_0000);
        check("intmin_hi", hi, 32'd0);
        run_op(1, 32'd12345, -32'sd17, 2);
        run_op(0, -32'sd9, -32'sd9, 0);
        run_op(0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(1, 32'd3, 32'd10, 0);

        for (int i = 0; i < 24; i++) begin
            rdiv = $urandom_range(0, 1);
            ra   = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(rdiv, ra, rb, int'($urandom_range(0, 1)));
        end

`ifdef MULDIV_MTHILO_EN
        begin
            logic [31:0] keep_lo;
            keep_lo = lo;
            src_a = 32'h1234; wr_hi = 1'b1;
            tick();
            wr_hi = 1'b0;
            check("mthi_hi", hi, 32'h1234);
            check("mthi_lo_keep", lo, keep_lo);
        end
`else
        begin
            logic [31:0] keep_hi;
            keep_hi = hi;
            src_a = 32'h1234; wr_hi = 1'b1;
            tick();
            check("mthi_ignored", hi, keep_hi);
            check("mthi_no_stall", {31'd0, stall}, 32'd0);
            wr_hi = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
